// File: rtl/cnt393_gate_ctrl_if.sv
// Bundle between the gated-count sequencer and its surroundings.
// The slave modport is the sequencer; the master modport is the measurement
// requester together with the external 74x393-style counter.
// Optional macro CNT393_GATE_CONT_EN adds the 'cont' request line.
interface cnt393_gate_ctrl_if #(
    parameter int W      = 8,
    parameter int GATE_W = 12
);
    // Measurement request side
    logic              start;
    logic [GATE_W-1:0] gate_len;
    logic              evt;
`ifdef CNT393_GATE_CONT_EN
    logic              cont;
`endif
    logic [W-1:0]      result;
    logic              done;
    logic              busy;
    logic              ovf;

    // External counter side
    logic              cnt_clk;
    logic              cnt_clr;
    logic [W-1:0]      cnt_q;

    modport master (
`ifdef CNT393_GATE_CONT_EN
        output cont,
`endif
        output start,
        output gate_len,
        output evt,
        output cnt_q,
        input  result,
        input  done,
        input  busy,
        input  ovf,
        input  cnt_clk,
        input  cnt_clr
    );

    modport slave (
`ifdef CNT393_GATE_CONT_EN
        input  cont,
`endif
        input  start,
        input  gate_len,
        input  evt,
        input  cnt_q,
        output result,
        output done,
        output busy,
        output ovf,
        output cnt_clk,
        output cnt_clr
    );
endinterface

// File: rtl/cnt393_gate_ctrl.sv
// Gated-count sequencer for a W-bit 74x393-style ripple counter.
// A measurement clears the external counter, opens a gate of gate_len clocks
// during which every rising edge of evt becomes one low pulse on cnt_clk,
// waits two cycles for the ripple to settle, then latches the counter value.
// A W+1-bit saturating shadow count tracks how many pulses were issued so an
// overflow of the external counter can be flagged.
// Optional macro CNT393_GATE_CONT_EN: adds a 'cont' input that chains windows
// back to back without returning to IDLE.
module cnt393_gate_ctrl #(
    parameter int W      = 8,
    parameter int GATE_W = 12
) (
    input  logic               clk,
    input  logic               clr,
    cnt393_gate_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_GATE    = 3'd2,
        S_SETTLE1 = 3'd3,
        S_SETTLE2 = 3'd4
    } state_t;

    // A zero-length gate is treated as a one-cycle gate.
    function automatic logic [GATE_W-1:0] cap_len(input logic [GATE_W-1:0] len);
        return (len == '0) ? GATE_W'(1) : len;
    endfunction

    // Shadow count sticks at all-ones instead of wrapping.
    function automatic logic [W:0] sat_inc(input logic [W:0] v);
        return (v == {(W+1){1'b1}}) ? v : v + (W+1)'(1);
    endfunction

    state_t            state_q,   state_d;
    logic [GATE_W-1:0] timer_q,   timer_d;
    logic [W:0]        shadow_q,  shadow_d;
    logic              evt_dly_q, evt_dly_d;
    logic              cnt_clk_q, cnt_clk_d;
    logic              cnt_clr_q, cnt_clr_d;
    logic [W-1:0]      result_q,  result_d;
    logic              ovf_q,     ovf_d;
    logic              done_q,    done_d;
    logic              busy_q,    busy_d;

    logic              rise;
    logic              cont_req;

`ifdef CNT393_GATE_CONT_EN
    assign cont_req = bus.cont;
`else
    assign cont_req = 1'b0;
`endif

    // evt is already synchronous; a rise is a 0->1 step against last cycle's value.
    assign rise = bus.evt & ~evt_dly_q;

    // Next-state and output decode; everything defaults to "hold" / idle levels.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        shadow_d  = shadow_q;
        evt_dly_d = bus.evt;
        cnt_clk_d = 1'b1;
        cnt_clr_d = 1'b0;
        result_d  = result_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    timer_d   = cap_len(bus.gate_len);
                    busy_d    = 1'b1;
                    cnt_clr_d = 1'b1;
                    state_d   = S_CLEAR;
                end
            end

            S_CLEAR: begin
                shadow_d = '0;
                state_d  = S_GATE;
            end

            S_GATE: begin
                // The low pulse is registered, so it lands in the following cycle;
                // a rise on the last gate cycle therefore pulses during SETTLE1.
                if (rise) begin
                    cnt_clk_d = 1'b0;
                    shadow_d  = sat_inc(shadow_q);
                end
                timer_d = timer_q - GATE_W'(1);
                if (timer_q == GATE_W'(1)) begin
                    state_d = S_SETTLE1;
                end
            end

            S_SETTLE1: begin
                state_d = S_SETTLE2;
            end

            S_SETTLE2: begin
                result_d = bus.cnt_q;
                ovf_d    = shadow_q[W];
                done_d   = 1'b1;
                if (cont_req) begin
                    timer_d   = cap_len(bus.gate_len);
                    cnt_clr_d = 1'b1;
                    state_d   = S_CLEAR;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; clr abandons any measurement in progress
    // and clears the external counter for one cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            shadow_q  <= '0;
            evt_dly_q <= 1'b0;
            cnt_clk_q <= 1'b1;
            cnt_clr_q <= 1'b1;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            shadow_q  <= shadow_d;
            evt_dly_q <= evt_dly_d;
            cnt_clk_q <= cnt_clk_d;
            cnt_clr_q <= cnt_clr_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.cnt_clk = cnt_clk_q;
    assign bus.cnt_clr = cnt_clr_q;
    assign bus.result  = result_q;
    assign bus.ovf     = ovf_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_cnt393_gate_ctrl.sv
// Bench for cnt393_gate_ctrl wired to a pair of 74x393-style 4-bit counters.
// Expected results come from the evt stimulus table and go through a queue.
module tb_cnt393_gate_ctrl;
    localparam int W      = 8;
    localparam int GATE_W = 12;
    localparam int MAXC   = 1024;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    cnt393_gate_ctrl_if #(.W(W), .GATE_W(GATE_W)) bus();
    cnt393_gate_ctrl #(.W(W), .GATE_W(GATE_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Ripple counter model: low nibble on falling cnt_clk, high nibble on falling lo[3].
    logic [3:0] lo_q = 4'd0;
    logic [3:0] hi_q = 4'd0;
    always @(negedge bus.cnt_clk or posedge bus.cnt_clr)
        if (bus.cnt_clr) lo_q <= 4'd0;
        else             lo_q <= lo_q + 4'd1;
    always @(negedge lo_q[3] or posedge bus.cnt_clr)
        if (bus.cnt_clr) hi_q <= 4'd0;
        else             hi_q <= hi_q + 4'd1;
    assign bus.cnt_q = {hi_q, lo_q};

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    bit   evt_seq[MAXC];
    bit   start_seq[MAXC];

    task automatic clear_seq();
        for (int i = 0; i < MAXC; i++) begin
            evt_seq[i]   = 1'b0;
            start_seq[i] = 1'b0;
        end
    endtask

    // Rises seen during gate cycles 1..N; cycle 0 is the CLEAR cycle.
    function automatic int exp_rises(input int len);
        int n;
        int r;
        n = (len == 0) ? 1 : len;
        r = 0;
        for (int j = 1; j <= n; j++)
            if (evt_seq[j] && !evt_seq[j-1]) r++;
        return r;
    endfunction

    task automatic push_exp(input int r);
        exp_t e;
        e.res = W'(r);
        e.ovf = (r > 255);
        sb_q.push_back(e);
    endtask

    // Drives one measurement; cycle c is the cycle after start-sampling edge c.
    task automatic run_window(input int len, output int done_cyc, output int pulses,
                              output int last_low, output int busy_bad);
        int n;
        n        = (len == 0) ? 1 : len;
        done_cyc = -1;
        pulses   = 0;
        last_low = -1;
        busy_bad = 0;
        bus.start    = 1'b1;
        bus.gate_len = GATE_W'(len);
        for (int c = 0; c < n + 20; c++) begin
            @(posedge clk); #1;
            bus.start = start_seq[c];
            bus.evt   = evt_seq[c];
            if (bus.cnt_clk === 1'b0) begin
                pulses++;
                last_low = c;
            end
            if (bus.done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad++;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.cnt_clr !== 1'b1) begin bad++; $display("FAIL reset_cnt_clr: got %b want 1", bus.cnt_clr); end
        total++; if (bus.cnt_clk !== 1'b1) begin bad++; $display("FAIL reset_cnt_clk: got %b want 1", bus.cnt_clk); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
        total++; if (bus.result !== 8'd0) begin bad++; $display("FAIL reset_result: got %0d want 0", bus.result); end
        clr = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.cnt_clr !== 1'b0) begin bad++; $display("FAIL reset_idle_cnt_clr: got %b want 0", bus.cnt_clr); end
    endtask

    task automatic test_basic();
        int dc, pl, ll, bb, r;
        exp_t e;
        clear_seq();
        evt_seq[1] = 1'b1; evt_seq[5] = 1'b1; evt_seq[9] = 1'b1;
        bus.evt = 1'b0;
        r = exp_rises(10);
        push_exp(r);
        run_window(10, dc, pl, ll, bb);
        e = sb_q.pop_front();
        total++; if (dc !== 13) begin bad++; $display("FAIL basic_latency: done at %0d want 13", dc); end
        total++; if (bus.result !== e.res) begin bad++; $display("FAIL basic_result: got %0d want %0d", bus.result, e.res); end
        total++; if (bus.ovf !== e.ovf) begin bad++; $display("FAIL basic_ovf: got %b want %b", bus.ovf, e.ovf); end
        total++; if (pl !== r) begin bad++; $display("FAIL basic_pulses: got %0d want %0d", pl, r); end
        total++; if (bb !== 0) begin bad++; $display("FAIL basic_busy_during: %0d cycles low want 0", bb); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", bus.busy); end
        @(posedge clk); #1;
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_overflow();
        int dc, pl, ll, bb, r;
        exp_t e;
        clear_seq();
        for (int c = 0; c < MAXC; c++) evt_seq[c] = c[0];
        bus.evt = 1'b1;
        r = exp_rises(600);
        push_exp(r);
        run_window(600, dc, pl, ll, bb);
        e = sb_q.pop_front();
        total++; if (dc !== 603) begin bad++; $display("FAIL ovf_latency: done at %0d want 603", dc); end
        total++; if (bus.result !== e.res) begin bad++; $display("FAIL ovf_result: got %0d want %0d", bus.result, e.res); end
        total++; if (bus.ovf !== e.ovf) begin bad++; $display("FAIL ovf_flag: got %b want %b", bus.ovf, e.ovf); end
        total++; if (pl !== r) begin bad++; $display("FAIL ovf_pulses: got %0d want %0d", pl, r); end
    endtask

    task automatic test_evt_held();
        int dc, pl, ll, bb, r;
        exp_t e;
        clear_seq();
        for (int c = 0; c < MAXC; c++) evt_seq[c] = 1'b1;
        bus.evt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        r = exp_rises(7);
        push_exp(r);
        run_window(7, dc, pl, ll, bb);
        e = sb_q.pop_front();
        total++; if (bus.result !== e.res) begin bad++; $display("FAIL held_result: got %0d want %0d", bus.result, e.res); end
        total++; if (bus.ovf !== e.ovf) begin bad++; $display("FAIL held_ovf: got %b want %b", bus.ovf, e.ovf); end
        total++; if (pl !== 0) begin bad++; $display("FAIL held_pulses: got %0d want 0", pl); end
        bus.evt = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_last_cycle_rise();
        int dc, pl, ll, bb, r;
        exp_t e;
        clear_seq();
        evt_seq[2] = 1'b1; evt_seq[6] = 1'b1;
        bus.evt = 1'b0;
        r = exp_rises(6);
        push_exp(r);
        run_window(6, dc, pl, ll, bb);
        e = sb_q.pop_front();
        total++; if (ll !== 7) begin bad++; $display("FAIL last_rise_pulse_cycle: got %0d want 7", ll); end
        total++; if (dc !== 9) begin bad++; $display("FAIL last_rise_latency: done at %0d want 9", dc); end
        total++; if (bus.result !== e.res) begin bad++; $display("FAIL last_rise_result: got %0d want %0d", bus.result, e.res); end
    endtask

    task automatic test_gate_zero();
        int dc, pl, ll, bb, r;
        exp_t e;
        clear_seq();
        evt_seq[1] = 1'b1;
        bus.evt = 1'b0;
        r = exp_rises(0);
        push_exp(r);
        run_window(0, dc, pl, ll, bb);
        e = sb_q.pop_front();
        total++; if (dc !== 4) begin bad++; $display("FAIL gate0_latency: done at %0d want 4", dc); end
        total++; if (bus.result !== e.res) begin bad++; $display("FAIL gate0_result: got %0d want %0d", bus.result, e.res); end
        total++; if (bb !== 0) begin bad++; $display("FAIL gate0_busy: %0d cycles low want 0", bb); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        clear_seq();
        evt_seq[1] = 1'b1; evt_seq[3] = 1'b1;
        bus.evt      = 1'b0;
        bus.start    = 1'b1;
        bus.gate_len = GATE_W'(10);
        for (int c = 0; c <= 5; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.evt   = evt_seq[c];
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        total++; if (bus.cnt_clr !== 1'b1) begin bad++; $display("FAIL rstmid_cnt_clr: got %b want 1", bus.cnt_clr); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        total++; if (bus.result !== 8'd0) begin bad++; $display("FAIL rstmid_result: got %0d want 0", bus.result); end
        total++; if (bus.cnt_q !== 8'd0) begin bad++; $display("FAIL rstmid_cnt_q: got %0d want 0", bus.cnt_q); end
        ndone = 0;
        bus.evt = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL rstmid_done: got %0d pulses want 0", ndone); end
        total++; if (bus.cnt_clr !== 1'b0) begin bad++; $display("FAIL rstmid_idle_clr: got %b want 0", bus.cnt_clr); end
    endtask

    task automatic test_ignored_start();
        int dc, pl, ll, bb, r, ndone;
        exp_t e;
        clear_seq();
        evt_seq[2] = 1'b1; evt_seq[6] = 1'b1;
        start_seq[3] = 1'b1; start_seq[11] = 1'b1; start_seq[12] = 1'b1;
        bus.evt = 1'b0;
        r = exp_rises(10);
        push_exp(r);
        run_window(10, dc, pl, ll, bb);
        e = sb_q.pop_front();
        total++; if (dc !== 13) begin bad++; $display("FAIL ign_latency: done at %0d want 13", dc); end
        total++; if (bus.result !== e.res) begin bad++; $display("FAIL ign_result: got %0d want %0d", bus.result, e.res); end
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL ign_restart: %0d active cycles want 0", ndone); end
        clear_seq();
        evt_seq[1] = 1'b1;
        r = exp_rises(3);
        push_exp(r);
        run_window(3, dc, pl, ll, bb);
        e = sb_q.pop_front();
        total++; if (dc !== 6) begin bad++; $display("FAIL ign_next_latency: done at %0d want 6", dc); end
        total++; if (bus.result !== e.res) begin bad++; $display("FAIL ign_next_result: got %0d want %0d", bus.result, e.res); end
    endtask

`ifdef CNT393_GATE_CONT_EN
    task automatic test_cont();
        int ndone, clr_bad, busy_bad;
        exp_t e;
        for (int k = 0; k < 3; k++) push_exp(2);
        ndone    = 0;
        clr_bad  = 0;
        busy_bad = 0;
        bus.evt      = 1'b0;
        bus.cont     = 1'b1;
        bus.start    = 1'b1;
        bus.gate_len = GATE_W'(8);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.evt   = ((c % 4) == 1);
            if (bus.cnt_clr !== (((c % 11) == 0) && (c <= 22))) clr_bad++;
            if (c < 33 && bus.busy !== 1'b1) busy_bad++;
            if (bus.done === 1'b1) begin
                ndone++;
                total++; if (c !== 11 * ndone) begin bad++; $display("FAIL cont_period: done at %0d want %0d", c, 11 * ndone); end
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    total++; if (bus.result !== e.res) begin bad++; $display("FAIL cont_result: got %0d want %0d", bus.result, e.res); end
                end
                if (ndone == 2) bus.cont = 1'b0;
            end
        end
        total++; if (ndone !== 3) begin bad++; $display("FAIL cont_windows: got %0d want 3", ndone); end
        total++; if (clr_bad !== 0) begin bad++; $display("FAIL cont_cnt_clr: %0d wrong cycles want 0", clr_bad); end
        total++; if (busy_bad !== 0) begin bad++; $display("FAIL cont_busy: %0d low cycles want 0", busy_bad); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL cont_busy_end: got %b want 0", bus.busy); end
    endtask
`endif

    initial begin
        bus.start    = 1'b0;
        bus.gate_len = '0;
        bus.evt      = 1'b0;
`ifdef CNT393_GATE_CONT_EN
        bus.cont     = 1'b0;
`endif
        clear_seq();
        test_reset();
        test_basic();
        test_overflow();
        test_evt_held();
        test_last_cycle_rise();
        test_gate_zero();
        test_reset_mid();
        test_ignored_start();
`ifdef CNT393_GATE_CONT_EN
        test_cont();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
